// File: rtl/pipelined_hamming_count.sv
// Pipelined set-bit / Hamming-distance counter. Optional macro HAMMING_COUNT_THRESH_EN adds thresh/out_below.
// Latency 2 + ceil(log2(ceil(WIDTH/CHUNK))) cycles, one result per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; all stages hold together.
module pipelined_hamming_count #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 8,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_count,
    output logic [TAG_W-1:0] out_tag
`ifdef HAMMING_COUNT_THRESH_EN
    ,
    input  logic [OUT_W-1:0] thresh,
    output logic             out_below
`endif
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int NLVL   = (NCHUNK > 1) ? $clog2(NCHUNK) : 0;
    localparam int PADW   = NCHUNK * CHUNK;

    // Width of a tree level l partial sum: its worst case is min(CHUNK*2^l, WIDTH).
    function automatic int sum_w(input int l);
        int m;
        m = CHUNK << l;
        if (m > WIDTH) m = WIDTH;
        return $clog2(m + 1);
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_sel;
    logic [PADW-1:0]  w_pad;
    logic             r_out_vld;
    logic [OUT_W-1:0] r_out_count;
    logic [TAG_W-1:0] r_out_tag;

    assign w_adv    = !r_out_vld || out_ready;
    assign in_ready = w_adv;
    assign w_sel    = in_mode ? (in_a ^ in_b) : in_a;
    assign w_pad    = PADW'(w_sel);

    for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
        localparam int N = (NCHUNK + (1 << l) - 1) >> l;
        localparam int W = sum_w(l);

        logic [W-1:0]     r_sum [N];
        logic             r_vld;
        logic [TAG_W-1:0] r_tag;
        logic [W-1:0]     w_sum [N];
        logic             w_vld;
        logic [TAG_W-1:0] w_tag;

        if (l == 0) begin : g_leaf
            always_comb begin
                logic [W-1:0] w_acc;
                for (int j = 0; j < N; j++) begin
                    w_acc = '0;
                    for (int b = 0; b < CHUNK; b++) begin
                        w_acc = w_acc + W'(w_pad[j*CHUNK+b]);
                    end
                    w_sum[j] = w_acc;
                end
            end
            assign w_vld = in_valid;
            assign w_tag = in_tag;
        end else begin : g_node
            localparam int NP = (NCHUNK + (1 << (l - 1)) - 1) >> (l - 1);
            for (genvar j = 0; j < N; j++) begin : g_add
                // An unpaired last element is carried up unchanged.
                if (2*j + 1 < NP) begin : g_pair
                    assign w_sum[j] = W'(g_lvl[l-1].r_sum[2*j]) + W'(g_lvl[l-1].r_sum[2*j+1]);
                end else begin : g_pass
                    assign w_sum[j] = W'(g_lvl[l-1].r_sum[2*j]);
                end
            end
            assign w_vld = g_lvl[l-1].r_vld;
            assign w_tag = g_lvl[l-1].r_tag;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_vld <= 1'b0;
                r_tag <= '0;
                for (int j = 0; j < N; j++) r_sum[j] <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld;
                r_tag <= w_tag;
                for (int j = 0; j < N; j++) r_sum[j] <= w_sum[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_vld   <= 1'b0;
            r_out_count <= '0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            r_out_vld   <= g_lvl[NLVL].r_vld;
            r_out_count <= OUT_W'(g_lvl[NLVL].r_sum[0]);
            r_out_tag   <= g_lvl[NLVL].r_tag;
        end
    end

`ifdef HAMMING_COUNT_THRESH_EN
    logic r_out_below;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_below <= 1'b0;
        end else if (w_adv) begin
            r_out_below <= (OUT_W'(g_lvl[NLVL].r_sum[0]) <= thresh);
        end
    end

    assign out_below = r_out_below;
`endif

    assign out_valid = r_out_vld;
    assign out_count = r_out_count;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_pipelined_hamming_count.sv
// Directed bench for pipelined_hamming_count: default 32/8 instance plus 20/8 and 8/8 geometry instances.
module tb_pipelined_hamming_count;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [7:0]  in_tag, out_tag;
    logic [5:0]  out_count;

    logic        s_valid, s_mode, s_ordy;
    logic [31:0] s_a, s_b;
    logic [7:0]  s_tag;
    logic        s20_ready, s20_valid, s8_ready, s8_valid;
    logic [4:0]  s20_count;
    logic [3:0]  s8_count;
    logic [7:0]  s20_tag, s8_tag;
`ifdef HAMMING_COUNT_THRESH_EN
    logic        out_below, s20_below, s8_below;
`endif

    pipelined_hamming_count dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_tag(out_tag)
`ifdef HAMMING_COUNT_THRESH_EN
        , .thresh(6'd5), .out_below(out_below)
`endif
    );

    pipelined_hamming_count #(.WIDTH(20), .CHUNK(8)) dut20 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s20_ready), .in_mode(s_mode),
        .in_a(s_a[19:0]), .in_b(s_b[19:0]), .in_tag(s_tag), .out_valid(s20_valid), .out_ready(s_ordy),
        .out_count(s20_count), .out_tag(s20_tag)
`ifdef HAMMING_COUNT_THRESH_EN
        , .thresh(5'd5), .out_below(s20_below)
`endif
    );

    pipelined_hamming_count #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s8_ready), .in_mode(s_mode),
        .in_a(s_a[7:0]), .in_b(s_b[7:0]), .in_tag(s_tag), .out_valid(s8_valid), .out_ready(s_ordy),
        .out_count(s8_count), .out_tag(s8_tag)
`ifdef HAMMING_COUNT_THRESH_EN
        , .thresh(4'd5), .out_below(s8_below)
`endif
    );

    typedef struct {
        int cnt;
        int tag;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   cur_exp = 0;
    bit   chk_lat = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: record accepted beats, retire presented results in order.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                exp_t e;
                n_out++;
                if (sb.size() == 0) begin
                    check("spurious_result", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("count", 32'(out_count), e.cnt);
                    check("tag", 32'(out_tag), e.tag);
                    if (chk_lat) check("latency", cyc - e.cyc, 32'd4);
`ifdef HAMMING_COUNT_THRESH_EN
                    check("below", 32'(out_below), 32'(e.cnt <= 5));
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back('{cnt: cur_exp, tag: int'(in_tag), cyc: cyc});
        end
    end

    task automatic send(input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] t, input int e);
        bit ok;
        in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_tag = t; cur_exp = e;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic small_beat(input logic m, input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] t, input int e20, input int e8);
        int lat20, lat8;
        s_valid = 1'b1; s_mode = m; s_a = a; s_b = b; s_tag = t;
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat20 = 0; lat8 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (s20_valid && lat20 == 0) begin
                lat20 = c;
                check("w20_count", 32'(s20_count), e20);
                check("w20_tag", 32'(s20_tag), 32'(t));
            end
            if (s8_valid && lat8 == 0) begin
                lat8 = c;
                check("w8_count", 32'(s8_count), e8);
                check("w8_tag", 32'(s8_tag), 32'(t));
            end
            @(posedge clk);
        end
        #1;
        check("w20_latency", lat20, 32'd4);
        check("w8_latency", lat8, 32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [31:0] ra, rb;
        logic        rm;
        rst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        s_valid = 1'b0; s_mode = 1'b0; s_a = '0; s_b = '0; s_tag = '0; s_ordy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_w20_valid", 32'(s20_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed vectors, back to back.
        send(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 8'h11, 32);
        send(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 8'h12, 32);
        send(1'b1, 32'h1234_5678, 32'h1234_5678, 8'h13, 0);
        send(1'b1, 32'h0000_000F, 32'h0000_0000, 8'h14, 4);
        send(1'b0, 32'h0000_00F0, 32'hFFFF_FFFF, 8'h15, 4);
        send(1'b0, 32'h0000_001F, 32'h0000_0000, 8'h16, 5);
        send(1'b0, 32'h0000_003F, 32'h0000_0000, 8'h17, 6);
        send(1'b0, 32'h8000_0001, 32'h0000_0000, 8'h18, 2);
        in_valid = 1'b0;
        drain();

        // Sixteen random beats, one per cycle.
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
            send(rm, ra, rb, 8'(8'h20 + i), $countones(rm ? (ra ^ rb) : ra));
        end
        in_valid = 1'b0;
        drain();
        check("burst_results", n_out - n0, 32'd16);

        // Fill the pipeline against a stalled output.
        chk_lat = 1'b0;
        out_ready = 1'b0;
        send(1'b0, 32'h0000_00FF, 32'h0, 8'h40, 8);
        send(1'b0, 32'h0000_0001, 32'h0, 8'h41, 1);
        send(1'b0, 32'h0000_0003, 32'h0, 8'h42, 2);
        send(1'b0, 32'h0000_0007, 32'h0, 8'h43, 3);
        in_valid = 1'b1; in_mode = 1'b0; in_a = 32'h0000_000F; in_b = '0; in_tag = 8'h44; cur_exp = 4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_count", 32'(out_count), 32'd8);
            check("stall_tag", 32'(out_tag), 32'h40);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b0, 32'h0000_000F, 32'h0, 8'h44, 4);
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b1;

        // Reset with beats in flight and one presented.
        out_ready = 1'b0;
        send(1'b0, 32'h0000_0001, 32'h0, 8'h50, 1);
        send(1'b0, 32'h0000_0003, 32'h0, 8'h51, 2);
        send(1'b0, 32'h0000_0007, 32'h0, 8'h52, 3);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        #1 rst = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_results", n_out - n0, 32'd0);
        send(1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 8'h60, 32);
        in_valid = 1'b0;
        drain();

        // Narrow geometries: padded last chunk and single chunk.
        small_beat(1'b0, 32'h000F_FFFF, 32'h0, 8'h70, 20, 8);
        small_beat(1'b1, 32'h000F_0F0F, 32'h0000_F0F0, 8'h71, 20, 8);
        small_beat(1'b0, 32'h0008_0001, 32'hFFFF_FFFF, 8'h72, 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_hamming_count.md
Name: pipelined_hamming_count

Overview:
Parametrised, pipelined successor to the combinational population counter used in the census matching path. Counts set bits of a WIDTH-bit vector, or of the XOR of two census vectors (Hamming distance), through a registered chunk/adder-tree pipeline. Valid/ready handshake with full backpressure and a sideband tag. Sits between the census transform windows and argmin disparity selection.

Parameters:
WIDTH, 32, bits per input vector (>=1)
CHUNK, 8, bits counted per first-stage chunk (1..WIDTH); NCHUNK = ceil(WIDTH/CHUNK), last chunk zero-padded
TAG_W, 8, width of sideband tag carried alongside each count (>=1)
OUT_W, $clog2(WIDTH+1), count width (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts beat this cycle
in_mode  input  1  0: popcount(in_a); 1: popcount(in_a ^ in_b)
in_a  input  WIDTH  primary census vector
in_b  input  WIDTH  reference census vector (ignored when in_mode=0)
in_tag  input  TAG_W  sideband (e.g. disparity index), passed unchanged
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_count  output  OUT_W  set-bit count
out_tag  output  TAG_W  tag of the beat producing out_count

Behaviour:
- Reset (rst low, async): all stage valid bits cleared; out_valid=0, out_count=0, out_tag=0; in_ready=1 once rst deasserted. Data registers may also be cleared; valid bits must be.
- Pipeline: stage 1 registers per-chunk counts of the selected vector (XOR/mode select combinational before stage 1); then ceil(log2(NCHUNK)) pairwise adder-tree stages (odd element passes through); final output register. LAT = 2 + ceil(log2(NCHUNK)); defaults give LAT=4; NCHUNK=1 gives LAT=2.
- Each stage holds valid, partial sums, tag. Partial sums sized to hold their maximum without overflow; no truncation anywhere; out_count range 0..WIDTH.
- Global stall: advance = !out_valid || out_ready. in_ready = advance. Beat accepted when in_valid && in_ready.
- When advance=1, every stage loads its predecessor (valid included; bubbles propagate as valid=0). When advance=0, all stages hold; out_count/out_tag stable while out_valid=1 and out_ready=0.
- Accepted beat appears at output exactly LAT cycles after acceptance if out_ready held 1; throughput one result per cycle.
- in_valid=0 with advance=1 inserts a bubble; no result produced for it.
- Order preserved; no beat dropped or duplicated under any in_valid/out_ready pattern.
- in_mode, in_b sampled only on accepted beats; in_b irrelevant when in_mode=0.
- rst asserted mid-stream: all in-flight beats discarded, out_valid falls asynchronously.

Optional Feature:
Macro HAMMING_COUNT_THRESH_EN. With it: adds input thresh (OUT_W, quasi-static) and output out_below (1): registered alongside out_count, equals (out_count <= thresh) for the presented beat, reset 0, held under stall like out_count. Without it: ports absent, no compare logic.

Test Plan:
- Reset then in_mode=0, in_a=32'hFFFFFFFF, tag=8'h11, out_ready=1 -> out_valid exactly 4 cycles later, out_count=32, out_tag=8'h11.
- in_mode=1, in_a=32'hA5A5A5A5, in_b=32'h5A5A5A5A -> count 32; in_a=in_b=32'h12345678 -> count 0; in_a=32'h0000000F, in_b=0 -> count 4.
- Back-to-back 16 random beats, out_ready=1 -> 16 consecutive results, in order, matching software model, one per cycle.
- out_ready low 5 cycles with pipeline full -> in_ready=0 throughout, out_count/out_tag stable, no loss; on release, remaining beats drain in order.
- rst pulsed low with 3 beats in flight -> out_valid=0 immediately; after release no stale results emerge.
- WIDTH=20, CHUNK=8 (padded last chunk, LAT=4); WIDTH=8, CHUNK=8 (LAT=2); with HAMMING_COUNT_THRESH_EN, thresh=5, counts 5 and 6 -> out_below 1 then 0.
